midi_note_receiver: RTL

Upstream front end for the note glyph managers. Receives the raw MIDI serial line from the keyboard at 31250 baud and parses Note On / Note Off messages, including running status. Drives the 16-bit midiNoteIn bus that the glyph managers compare against, with {note, velocity} packing. The bus holds the currently pressed key and returns to 0 on that key's release.

---
 rtl/midi_pkg.sv | 26 ++
 rtl/midi_uart_rx.sv | 113 +++++++++++
 rtl/midi_note_receiver.sv | 106 ++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared constants and enums for the MIDI note receiver.
// Status nibbles, running-status encoding and UART states.
package midi_pkg;

    localparam int unsigned MIDI_BAUD = 31250;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] SYS      = 4'hF;

    typedef enum logic [1:0] {
        RsNone,
        RsOn,
        RsOff,
        RsIgnore
    } run_status_t;

    typedef enum logic [2:0] {
        UartIdle,
        UartStart,
        UartData,
        UartStop,
        UartWaitHigh
    } uart_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART receiver: 2-flop synchronizer, 8N1 framing, one-cycle byte strobe
// or framing-error strobe per received frame.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 800
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic       midiRx,
    output logic [7:0] byteData,
    output logic       byteValid,
    output logic       framingError
);

    localparam logic [11:0] HALF_CNT = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_CNT = 12'(CLKS_PER_BIT - 1);

    logic [1:0]  r_sync;
    uart_state_t r_state, w_state_d;
    logic [11:0] r_cnt, w_cnt_d;
    logic [2:0]  r_bit_idx, w_bit_idx_d;
    logic [7:0]  r_shift, w_shift_d;
    logic        r_byte_valid, w_byte_valid_d;
    logic        r_frame_err, w_frame_err_d;
    logic        w_rx;

    assign w_rx         = r_sync[1];
    assign byteData     = r_shift;
    assign byteValid    = r_byte_valid;
    assign framingError = r_frame_err;

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            r_sync       <= 2'b11;
            r_state      <= UartIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], midiRx};
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_byte_valid <= w_byte_valid_d;
            r_frame_err  <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_byte_valid_d = 1'b0;
        w_frame_err_d  = 1'b0;
        unique case (r_state)
            UartIdle: begin
                if (!w_rx) begin
                    w_state_d = UartStart;
                    w_cnt_d   = '0;
                end
            end
            UartStart: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_d     = '0;
                    w_bit_idx_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch
                    w_state_d   = w_rx ? UartIdle : UartData;
                end else begin
                    w_cnt_d = r_cnt + 12'd1;
                end
            end
            UartData: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_rx, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = UartStop;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 12'd1;
                end
            end
            UartStop: begin
                if (r_cnt == FULL_CNT) begin
                    w_cnt_d = '0;
                    if (w_rx) begin
                        w_byte_valid_d = 1'b1;
                        w_state_d      = UartIdle;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = UartWaitHigh;
                    end
                end else begin
                    w_cnt_d = r_cnt + 12'd1;
                end
            end
            UartWaitHigh: begin
                if (w_rx) begin
                    w_state_d = UartIdle;
                end
            end
            default: w_state_d = UartIdle;
        endcase
    end

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI Note On/Off parser with running status; drives the {note, velocity}
// bus of the currently held key for the glyph managers.
module midi_note_receiver
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 800,
    parameter logic [3:0]  CHANNEL      = 4'd0,
    parameter bit          OMNI         = 1'b1
) (
    input  logic        pixelClk,
    input  logic        reset,
    input  logic        midiRx,
    output logic [15:0] midiNoteOut,
    output logic        noteOnPulse,
    output logic        noteOffPulse,
    output logic        framingError
);

    logic [7:0]  w_byte_data;
    logic        w_byte_valid;

    run_status_t r_rs, w_rs_d;
    logic        r_have_note, w_have_note_d;
    logic [7:0]  r_note, w_note_d;
    logic [15:0] r_out, w_out_d;
    logic        r_on, w_on_d;
    logic        r_off, w_off_d;
    logic        w_ch_ok;

    midi_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .pixelClk    (pixelClk),
        .reset       (reset),
        .midiRx      (midiRx),
        .byteData    (w_byte_data),
        .byteValid   (w_byte_valid),
        .framingError(framingError)
    );

    assign midiNoteOut  = r_out;
    assign noteOnPulse  = r_on;
    assign noteOffPulse = r_off;
    assign w_ch_ok      = OMNI || (w_byte_data[3:0] == CHANNEL);

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            r_rs        <= RsNone;
            r_have_note <= 1'b0;
            r_note      <= '0;
            r_out       <= '0;
            r_on        <= 1'b0;
            r_off       <= 1'b0;
        end else begin
            r_rs        <= w_rs_d;
            r_have_note <= w_have_note_d;
            r_note      <= w_note_d;
            r_out       <= w_out_d;
            r_on        <= w_on_d;
            r_off       <= w_off_d;
        end
    end

    always_comb begin
        w_rs_d        = r_rs;
        w_have_note_d = r_have_note;
        w_note_d      = r_note;
        w_out_d       = r_out;
        w_on_d        = 1'b0;
        w_off_d       = 1'b0;
        if (w_byte_valid) begin
            if (w_byte_data[7]) begin
                // Realtime bytes (F8-FF) leave running status and data phase untouched
                if (w_byte_data[7:3] != 5'b11111) begin
                    w_have_note_d = 1'b0;
                    if (w_byte_data[7:4] == NOTE_ON) begin
                        w_rs_d = w_ch_ok ? RsOn : RsIgnore;
                    end else if (w_byte_data[7:4] == NOTE_OFF) begin
                        w_rs_d = w_ch_ok ? RsOff : RsIgnore;
                    end else if (w_byte_data[7:4] == SYS) begin
                        w_rs_d = RsNone;
                    end else begin
                        w_rs_d = RsIgnore;
                    end
                end
            end else if (r_rs == RsOn || r_rs == RsOff) begin
                if (!r_have_note) begin
                    w_note_d      = w_byte_data;
                    w_have_note_d = 1'b1;
                end else begin
                    w_have_note_d = 1'b0;
                    if (r_rs == RsOn && w_byte_data != 8'd0) begin
                        w_out_d = {r_note, w_byte_data};
                        w_on_d  = 1'b1;
                    end else begin
                        w_off_d = 1'b1;
                        if (r_note == r_out[15:8]) begin
                            w_out_d = '0;
                        end
                    end
                end
            end
        end
    end

endmodule
